// File: rtl/gpio_int_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_int_arbiter
//
// Interrupt scheduler between the 16-line GPIO interrupt block and the CPU
// bus. Masks the GPIO block's sticky status, picks one pending line
// round-robin, presents it as a vector and raises Irq. A software
// acknowledge produces a one-cycle clear pulse back to the GPIO block. A
// programmable hold-off follows before the next arbitration.
//
// Ports:
//   Clk        system clock, all state changes on posedge
//   Reset      asynchronous, active-high reset
//   Addr       register select (0 Mask, 1 Vector, 2 Ack, 3 Pending, 4 HoldReg)
//   DataRd     register read data (combinational, 0 when En=0)
//   DataWr     register write data
//   En         block select
//   Rd         read strobe (reads have no side effects, so it is not decoded)
//   Wr         write strobe, qualified by En
//   IntStatus  sticky per-line status from the GPIO interrupt block
//   IntReset   registered one-hot clear pulse to the GPIO interrupt block
//   Irq        registered interrupt request to the CPU
// ---------------------------------------------------------------------------
module gpio_int_arbiter #(
  parameter int HOLD_W       = 8,
  parameter int HOLDOFF_INIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  Addr,
  output logic [15:0] DataRd,
  input  logic [15:0] DataWr,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] IntStatus,
  output logic [15:0] IntReset,
  output logic        Irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  logic [15:0]         r_mask;
  logic [HOLD_W-1:0]   r_hold_reg;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [3:0]          r_cur_idx;
  logic [3:0]          r_last_idx;
  logic                r_irq;
  logic [15:0]         r_int_reset;

  logic [15:0]         w_pending;
  logic [4:0]          w_pick;
  logic                w_mask_we;
  logic                w_hold_we;
  logic                w_ack;
  logic [15:0]         w_data_rd;
  logic                w_unused_rd;

  // Round-robin pick: bit 4 flags a winner, bits 3:0 are its index. The
  // search starts one past the last granted line; 4-bit index arithmetic
  // provides the 15->0 wrap.
  function automatic logic [4:0] f_rr_pick(input logic [15:0] pend,
                                           input logic [3:0]  last);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int i = 0; i < 16; i++) begin
      idx = last + 4'd1 + 4'(i);
      if (!res[4] && pend[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign w_pending   = IntStatus & r_mask;
  assign w_pick      = f_rr_pick(w_pending, r_last_idx);
  assign w_mask_we   = En & Wr & (Addr == 3'd0);
  assign w_ack       = En & Wr & (Addr == 3'd2);
  assign w_hold_we   = En & Wr & (Addr == 3'd4);
  assign w_unused_rd = Rd;

  // Register read mux; Ack and unused addresses read as zero.
  always_comb begin
    w_data_rd = 16'd0;
    if (En) begin
      case (Addr)
        3'd0:    w_data_rd = r_mask;
        3'd1:    w_data_rd = {(r_state == ST_ASSERT), 11'd0, r_cur_idx};
        3'd3:    w_data_rd = w_pending;
        3'd4:    w_data_rd = 16'(r_hold_reg);
        default: w_data_rd = 16'd0;
      endcase
    end else begin
      w_data_rd = 16'd0;
    end
  end

  assign DataRd   = w_data_rd;
  assign IntReset = r_int_reset;
  assign Irq      = r_irq;

  // Config registers, scheduler FSM and its registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_mask      <= 16'd0;
      r_hold_reg  <= HOLD_W'(HOLDOFF_INIT);
      r_hold_cnt  <= {HOLD_W{1'b0}};
      r_cur_idx   <= 4'd0;
      r_last_idx  <= 4'd15;
      r_irq       <= 1'b0;
      r_int_reset <= 16'd0;
    end else begin
      if (w_mask_we) begin
        r_mask <= DataWr;
      end
      // The running hold-off count is loaded only on CLEAR, so writing
      // HoldReg mid-hold affects the next hold-off only.
      if (w_hold_we) begin
        r_hold_reg <= DataWr[HOLD_W-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          r_irq       <= 1'b0;
          r_int_reset <= 16'd0;
          if (w_pick[4]) begin
            r_cur_idx <= w_pick[3:0];
            r_irq     <= 1'b1;
            r_state   <= ST_ASSERT;
          end
        end
        // The vector is frozen here; mask/status changes do not withdraw it.
        ST_ASSERT: begin
          if (w_ack) begin
            r_irq       <= 1'b0;
            r_int_reset <= 16'd1 << r_cur_idx;
            r_state     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_int_reset <= 16'd0;
          r_last_idx  <= r_cur_idx;
          r_hold_cnt  <= r_hold_reg;
          r_state     <= ST_HOLD;
        end
        // At least one HOLD cycle always elapses so the GPIO status bit
        // cleared by the pulse has settled before re-arbitrating.
        ST_HOLD: begin
          if (r_hold_cnt == {HOLD_W{1'b0}}) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          r_irq       <= 1'b0;
          r_int_reset <= 16'd0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_int_arbiter.sv
module tb_gpio_int_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  Addr;
  logic [15:0] DataRd;
  logic [15:0] DataWr;
  logic        En;
  logic        Rd;
  logic        Wr;
  logic [15:0] IntStatus;
  logic [15:0] IntReset;
  logic        Irq;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  gpio_int_arbiter #(.HOLD_W(8), .HOLDOFF_INIT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
    .En(En), .Rd(Rd), .Wr(Wr), .IntStatus(IntStatus), .IntReset(IntReset),
    .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge Clk);
    En = 1'b1; Wr = 1'b1; Addr = a; DataWr = d;
    @(negedge Clk);
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge Clk);
    En = 1'b1; Rd = 1'b1; Addr = a;
    #1;
    d = DataRd;
    En = 1'b0; Rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_irq(input string tag, output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Irq) begin
        got = 1'b1;
        break;
      end
    end
    check_eq({tag, "_irq_seen"}, {15'd0, got}, 16'd1);
  endtask

  // Pops the next expected grant, checks the vector, acknowledges and checks
  // the one-cycle clear pulse. Returns at the first HOLD-cycle negedge.
  task automatic take_grant(input string tag, input bit clear_status);
    logic [15:0] v;
    int          e;
    bit          got;
    wait_irq(tag, got);
    if (got) begin
      bus_read(3'd1, v);
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, v, 16'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, "_vec"}, v, 16'h8000 | 16'(e));
        bus_write(3'd2, 16'h0001);
        check_eq({tag, "_pulse"}, IntReset, 16'd1 << e);
        check_eq({tag, "_irq_clr"}, {15'd0, Irq}, 16'd0);
        @(negedge Clk);
        check_eq({tag, "_pulse_end"}, IntReset, 16'd0);
        if (clear_status) begin
          IntStatus = IntStatus & ~(16'd1 << e);
        end
      end
    end
  endtask

  // Counts negedges from the first HOLD negedge until Irq returns; can
  // optionally write HoldReg=0 during the hold.
  task automatic check_latency(input string tag, input int exp_n, input bit poke);
    int n;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 1) begin
        En = 1'b1; Wr = 1'b1; Addr = 3'd4; DataWr = 16'd0;
      end
      @(negedge Clk);
      if (poke && k == 1) begin
        En = 1'b0; Wr = 1'b0;
      end
      if (Irq) begin
        n = k;
        break;
      end
    end
    check_eq(tag, 16'(n), 16'(exp_n));
  endtask

  initial begin
    logic [15:0] rd;
    bit          got;
    Reset = 1'b1; En = 1'b0; Rd = 1'b0; Wr = 1'b0;
    Addr = 3'd0; DataWr = 16'd0; IntStatus = 16'd0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Reset state
    check_eq("rst_irq", {15'd0, Irq}, 16'd0);
    check_eq("rst_intreset", IntReset, 16'd0);
    bus_read(3'd0, rd); check_eq("rst_mask", rd, 16'h0000);
    bus_read(3'd1, rd); check_eq("rst_vector", rd, 16'h0000);
    bus_read(3'd4, rd); check_eq("rst_holdreg", rd, 16'h0004);
    bus_read(3'd3, rd); check_eq("rst_pending", rd, 16'h0000);
    bus_read(3'd2, rd); check_eq("rd_ack_zero", rd, 16'h0000);
    bus_read(3'd6, rd); check_eq("rd_addr6_zero", rd, 16'h0000);
    check_eq("rd_en_low", DataRd, 16'h0000);

    // Basic grant of line 5 with one-cycle Irq latency, then idle after clear
    bus_write(3'd0, 16'hFFFF);
    IntStatus = 16'h0020;
    check_eq("basic_irq_pre", {15'd0, Irq}, 16'd0);
    @(negedge Clk);
    check_eq("basic_irq_rise", {15'd0, Irq}, 16'd1);
    bus_read(3'd3, rd); check_eq("basic_pending", rd, 16'h0020);
    exp_q.push_back(5);
    take_grant("basic", 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      check_eq("basic_quiet_irq", {15'd0, Irq}, 16'd0);
      check_eq("basic_quiet_intreset", IntReset, 16'd0);
    end

    // Hold-off latency, HoldReg written mid-hold, then HoldReg=0
    IntStatus = 16'h0020;
    exp_q.push_back(5); take_grant("lat4", 1'b0); check_latency("lat4_cycles", 6, 1'b0);
    exp_q.push_back(5); take_grant("latp", 1'b0); check_latency("latpoke_cycles", 6, 1'b1);
    exp_q.push_back(5); take_grant("lat0", 1'b0); check_latency("lat0_cycles", 2, 1'b0);
    exp_q.push_back(5); take_grant("latend", 1'b1);

    // Round-robin between lines 0 and 15, status never cleared
    IntStatus = 16'h0000;
    do_reset();
    bus_write(3'd4, 16'h0000);
    bus_write(3'd0, 16'hFFFF);
    IntStatus = 16'h8001;
    exp_q.push_back(0); exp_q.push_back(15); exp_q.push_back(0); exp_q.push_back(15);
    for (int g = 0; g < 4; g++) take_grant("rr_8001", 1'b0);

    // Round-robin over lines 0..2
    IntStatus = 16'h0000;
    do_reset();
    bus_write(3'd4, 16'h0000);
    bus_write(3'd0, 16'hFFFF);
    IntStatus = 16'h0007;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    for (int g = 0; g < 4; g++) take_grant("rr_0007", 1'b0);

    // Masking
    IntStatus = 16'h0000;
    do_reset();
    bus_write(3'd0, 16'h00FF);
    IntStatus = 16'h0100;
    repeat (3) @(negedge Clk);
    check_eq("mask_irq_blocked", {15'd0, Irq}, 16'd0);
    bus_read(3'd3, rd); check_eq("mask_pending_zero", rd, 16'h0000);
    bus_write(3'd0, 16'h0100);
    check_eq("mask_write_next_cycle", {15'd0, Irq}, 16'd0);
    @(negedge Clk);
    check_eq("mask_irq_rise", {15'd0, Irq}, 16'd1);
    bus_read(3'd1, rd); check_eq("mask_vector", rd, 16'h8008);
    bus_write(3'd0, 16'h0000);
    repeat (4) @(negedge Clk);
    check_eq("mask_cleared_irq_held", {15'd0, Irq}, 16'd1);
    bus_read(3'd1, rd); check_eq("mask_cleared_vector", rd, 16'h8008);
    exp_q.push_back(8);
    take_grant("mask", 1'b1);

    // Ack ignored in HOLD and in IDLE
    bus_write(3'd2, 16'h0001);
    check_eq("ack_hold_intreset", IntReset, 16'd0);
    check_eq("ack_hold_irq", {15'd0, Irq}, 16'd0);
    repeat (8) @(negedge Clk);
    bus_write(3'd2, 16'h0001);
    check_eq("ack_idle_intreset", IntReset, 16'd0);
    @(negedge Clk);
    check_eq("ack_idle_intreset2", IntReset, 16'd0);
    check_eq("ack_idle_irq", {15'd0, Irq}, 16'd0);
    bus_write(3'd0, 16'hFFFF);
    IntStatus = 16'h0010;
    exp_q.push_back(4);
    take_grant("after_ignored", 1'b1);

    // Ack in the same cycle Pending first rises is ignored
    repeat (8) @(negedge Clk);
    IntStatus = 16'h0002;
    En = 1'b1; Wr = 1'b1; Addr = 3'd2; DataWr = 16'h0001;
    @(negedge Clk);
    En = 1'b0; Wr = 1'b0;
    check_eq("ack_same_irq", {15'd0, Irq}, 16'd1);
    check_eq("ack_same_intreset", IntReset, 16'd0);
    @(negedge Clk);
    check_eq("ack_same_irq_held", {15'd0, Irq}, 16'd1);
    exp_q.push_back(1);
    take_grant("ack_same", 1'b1);

    // Asynchronous reset in CLEAR
    IntStatus = 16'h0040;
    wait_irq("areset", got);
    bus_write(3'd2, 16'h0001);
    check_eq("areset_pulse", IntReset, 16'h0040);
    #2;
    Reset = 1'b1;
    #1;
    check_eq("areset_intreset", IntReset, 16'd0);
    check_eq("areset_irq", {15'd0, Irq}, 16'd0);
    IntStatus = 16'h0000;
    @(negedge Clk);
    Reset = 1'b0;
    bus_write(3'd0, 16'hFFFF);
    IntStatus = 16'h0003;
    exp_q.push_back(0);
    take_grant("post_reset", 1'b1);

    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
